fab_apb_bridge: RTL and testbench

- Fabric-side APB3 bridge that fans one MSS APB master out to `NUM_SLOTS` fabric slaves. Each slave gets its own address window.
- Registers the whole transaction through a small FSM, so the slave side is cleanly isolated from the master side.
- Adds a per-access timeout and an error counter with an interrupt pulse.
- Instantiated in the top level next to the MSS wrapper, clocked by the CCC fabric clock; it replaces the tied-off master-side APB (MSSP*) connections.

---
 rtl/fab_apb_pkg.sv | 26 ++
 rtl/fab_apb_decode.sv | 36 +++
 rtl/fab_apb_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_fab_apb_bridge.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fab_apb_pkg.sv
`timescale 1ns/1ps
// fab_apb_pkg: shared types and constants for the fabric-side APB3 bridge.
package fab_apb_pkg;

  // APB data path width on both the master and the slave side.
  localparam int APB_DW = 32;

  // Width of the saturating error-response counter.
  localparam int ERR_CW = 16;

  // Bridge transaction states.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    DECERR,
    RESP
  } state_e;

  // Slot-select field width. A single slave still decodes one select bit,
  // so the address tag always starts above the slot field.
  function automatic int sel_width(input int num_slots);
    return (num_slots <= 1) ? 1 : $clog2(num_slots);
  endfunction

endpackage

// File: rtl/fab_apb_decode.sv
`timescale 1ns/1ps
// fab_apb_decode: maps a master APB address onto a fabric slave slot.
// Purely combinational. An address is mapped when its tag matches the
// bridge base and its slot field names an existing slave.
module fab_apb_decode
  import fab_apb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_SLOTS = 4,
  parameter int                SLOT_AW   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4005_0000,
  localparam int               SEL_W     = sel_width(NUM_SLOTS)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [SEL_W-1:0]  slot_o
);

  // Tag field sits above the per-slave window and the slot select bits.
  localparam int TAG_LO = SLOT_AW + SEL_W;

  // One extra bit so NUM_SLOTS itself is representable (e.g. 16 slots).
  localparam logic [SEL_W:0] SLOT_LIMIT = (SEL_W + 1)'(NUM_SLOTS);

  logic             tag_match;
  logic [SEL_W-1:0] slot;

  // Compare the tag against the base and range-check the slot index.
  always_comb begin
    slot      = addr_i[SLOT_AW +: SEL_W];
    tag_match = (addr_i[ADDR_W-1:TAG_LO] == BASE_ADDR[ADDR_W-1:TAG_LO]);
    hit_o     = tag_match && ({1'b0, slot} < SLOT_LIMIT);
    slot_o    = slot;
  end

endmodule

// File: rtl/fab_apb_bridge.sv
`timescale 1ns/1ps
// fab_apb_bridge: fans one MSS APB3 master out to NUM_SLOTS fabric slaves.
// Every transfer is re-registered through a small FSM so the slave bus is
// isolated from the master bus. Adds a per-access timeout, a saturating
// error counter and a one-cycle error interrupt. All outputs are registered.
module fab_apb_bridge
  import fab_apb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_SLOTS = 4,
  parameter int                SLOT_AW   = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h4005_0000,
  parameter int                TIMEOUT   = 255
) (
  input  logic                        FAB_CLK,
  input  logic                        FAB_RESET,
  // master side
  input  logic [ADDR_W-1:0]           m_paddr,
  input  logic                        m_psel,
  input  logic                        m_penable,
  input  logic                        m_pwrite,
  input  logic [APB_DW-1:0]           m_pwdata,
  output logic [APB_DW-1:0]           m_prdata,
  output logic                        m_pready,
  output logic                        m_pslverr,
  // slave side
  output logic [NUM_SLOTS-1:0]        s_psel,
  output logic [SLOT_AW-1:0]          s_paddr,
  output logic                        s_penable,
  output logic                        s_pwrite,
  output logic [APB_DW-1:0]           s_pwdata,
  input  logic [NUM_SLOTS*APB_DW-1:0] s_prdata,
  input  logic [NUM_SLOTS-1:0]        s_pready,
  input  logic [NUM_SLOTS-1:0]        s_pslverr,
  // error reporting
  output logic [ERR_CW-1:0]           err_count,
  output logic                        err_irq
);

  localparam int SEL_W = sel_width(NUM_SLOTS);
  // Timer must be able to hold TIMEOUT itself; one bit when disabled.
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  // FSM and transfer context
  state_e             state_q, state_d;
  logic [SLOT_AW-1:0] addr_q, addr_d;
  logic [APB_DW-1:0]  wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [SEL_W-1:0]   slot_q, slot_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  // Response captured on the transition into RESP
  logic [APB_DW-1:0]  resp_data_d;
  logic               resp_err_d;

  // Registered outputs
  logic [NUM_SLOTS-1:0] s_psel_q, s_psel_d;
  logic                 s_penable_q, s_penable_d;
  logic                 m_pready_q, m_pready_d;
  logic [APB_DW-1:0]    m_prdata_q, m_prdata_d;
  logic                 m_pslverr_q, m_pslverr_d;
  logic [ERR_CW-1:0]    err_cnt_q, err_cnt_d;
  logic                 err_irq_q, err_irq_d;

  // Decode and selected-slave response
  logic              dec_hit;
  logic [SEL_W-1:0]  dec_slot;
  logic [APB_DW-1:0] sel_rdata;
  logic              sel_ready;
  logic              sel_err;

  fab_apb_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_AW   (SLOT_AW),
    .BASE_ADDR (BASE_ADDR)
  ) u_decode (
    .addr_i (m_paddr),
    .hit_o  (dec_hit),
    .slot_o (dec_slot)
  );

  // Pick the ready, error and read data of the slave owning this transfer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_q == SEL_W'(k)) begin
        sel_rdata = s_prdata[k*APB_DW +: APB_DW];
        sel_ready = s_pready[k];
        sel_err   = s_pslverr[k];
      end
    end
  end

  // State, context and output registers with synchronous reset.
  always_ff @(posedge FAB_CLK) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge regardless of statement order.
    if (FAB_RESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      slot_q      <= '0;
      timer_q     <= '0;
      s_psel_q    <= '0;
      s_penable_q <= 1'b0;
      m_pready_q  <= 1'b0;
      m_prdata_q  <= '0;
      m_pslverr_q <= 1'b0;
      err_cnt_q   <= '0;
      err_irq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      slot_q      <= slot_d;
      timer_q     <= timer_d;
      s_psel_q    <= s_psel_d;
      s_penable_q <= s_penable_d;
      m_pready_q  <= m_pready_d;
      m_prdata_q  <= m_prdata_d;
      m_pslverr_q <= m_pslverr_d;
      err_cnt_q   <= err_cnt_d;
      err_irq_q   <= err_irq_d;
    end
  end

  // Next-state logic: transfer latching, wait timer and response capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    slot_d      = slot_q;
    timer_d     = timer_q;
    resp_data_d = '0;
    resp_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (m_psel && !m_penable) begin
          addr_d  = m_paddr[SLOT_AW-1:0];
          wdata_d = m_pwdata;
          write_d = m_pwrite;
          slot_d  = dec_slot;
          state_d = dec_hit ? SETUP : DECERR;
        end
      end

      SETUP: begin
        timer_d = '0;
        state_d = ACCESS;
      end

      ACCESS: begin
        // A ready slave wins over a timer that expires in the same cycle.
        if (sel_ready) begin
          resp_data_d = sel_rdata;
          resp_err_d  = sel_err;
          state_d     = RESP;
        end else if ((TIMEOUT != 0) && (timer_q == TMR_LIMIT)) begin
          resp_err_d = 1'b1;
          state_d    = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DECERR: begin
        resp_err_d = 1'b1;
        state_d    = RESP;
      end

      RESP: begin
        // The master is released whether or not it still holds psel.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: derived from the next state so outputs leave a register.
  always_comb begin
    logic in_xfer;
    logic in_resp;

    in_xfer = (state_d == SETUP) || (state_d == ACCESS);
    in_resp = (state_d == RESP);

    s_psel_d = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      s_psel_d[k] = in_xfer && (slot_d == SEL_W'(k));
    end
    s_penable_d = (state_d == ACCESS);

    m_pready_d  = in_resp;
    m_prdata_d  = in_resp ? resp_data_d : '0;
    m_pslverr_d = in_resp && resp_err_d;

    err_irq_d = in_resp && resp_err_d;
    err_cnt_d = err_cnt_q;
    if (err_irq_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  assign s_psel    = s_psel_q;
  assign s_penable = s_penable_q;
  assign s_paddr   = addr_q;
  assign s_pwrite  = write_q;
  assign s_pwdata  = wdata_q;
  assign m_pready  = m_pready_q;
  assign m_prdata  = m_prdata_q;
  assign m_pslverr = m_pslverr_q;
  assign err_count = err_cnt_q;
  assign err_irq   = err_irq_q;

endmodule

// File: tb/tb_fab_apb_bridge.sv
`timescale 1ns/1ps
// tb_fab_apb_bridge: directed stimulus with a scoreboard for fab_apb_bridge.
// The stimulus pushes the expected response of each transfer; a monitor
// pops and compares whenever the bridge raises m_pready. A second instance
// with a short timeout covers the forced-error path.
module tb_fab_apb_bridge;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    logic [15:0] cnt;
  } exp_t;

  logic        FAB_CLK = 1'b0;
  logic        FAB_RESET = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model_cnt = '0;

  // main instance
  logic [31:0]  m_paddr = '0;
  logic         m_psel = 1'b0, m_penable = 1'b0, m_pwrite = 1'b0;
  logic [31:0]  m_pwdata = '0;
  logic [31:0]  m_prdata;
  logic         m_pready, m_pslverr;
  logic [3:0]   s_psel;
  logic [7:0]   s_paddr;
  logic         s_penable, s_pwrite;
  logic [31:0]  s_pwdata;
  logic [127:0] s_prdata;
  logic [3:0]   s_pready, s_pslverr;
  logic [15:0]  err_count;
  logic         err_irq;

  // timeout instance
  logic [31:0]  t_m_paddr = '0;
  logic         t_m_psel = 1'b0, t_m_penable = 1'b0, t_m_pwrite = 1'b0;
  logic [31:0]  t_m_pwdata = '0;
  logic [31:0]  t_m_prdata;
  logic         t_m_pready, t_m_pslverr;
  logic [3:0]   t_s_psel;
  logic [7:0]   t_s_paddr;
  logic         t_s_penable, t_s_pwrite;
  logic [31:0]  t_s_pwdata;
  logic [127:0] t_s_prdata;
  logic [3:0]   t_s_pready, t_s_pslverr;
  logic [15:0]  t_err_count;
  logic         t_err_irq;

  // slave model: per-slot wait count (-1 = never ready), data and error
  int          sl_wait[4] = '{0, 0, 0, 0};
  logic [31:0] sl_data[4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic        sl_err[4]  = '{1'b0, 1'b0, 1'b0, 1'b0};
  int          acc_cnt[4] = '{0, 0, 0, 0};

  fab_apb_bridge dut (
    .FAB_CLK   (FAB_CLK),   .FAB_RESET (FAB_RESET),
    .m_paddr   (m_paddr),   .m_psel    (m_psel),    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),  .m_pwdata  (m_pwdata),  .m_prdata  (m_prdata),
    .m_pready  (m_pready),  .m_pslverr (m_pslverr),
    .s_psel    (s_psel),    .s_paddr   (s_paddr),   .s_penable (s_penable),
    .s_pwrite  (s_pwrite),  .s_pwdata  (s_pwdata),  .s_prdata  (s_prdata),
    .s_pready  (s_pready),  .s_pslverr (s_pslverr),
    .err_count (err_count), .err_irq   (err_irq)
  );

  fab_apb_bridge #(.TIMEOUT(4)) dut_to (
    .FAB_CLK   (FAB_CLK),     .FAB_RESET (FAB_RESET),
    .m_paddr   (t_m_paddr),   .m_psel    (t_m_psel),    .m_penable (t_m_penable),
    .m_pwrite  (t_m_pwrite),  .m_pwdata  (t_m_pwdata),  .m_prdata  (t_m_prdata),
    .m_pready  (t_m_pready),  .m_pslverr (t_m_pslverr),
    .s_psel    (t_s_psel),    .s_paddr   (t_s_paddr),   .s_penable (t_s_penable),
    .s_pwrite  (t_s_pwrite),  .s_pwdata  (t_s_pwdata),  .s_prdata  (t_s_prdata),
    .s_pready  (t_s_pready),  .s_pslverr (t_s_pslverr),
    .err_count (t_err_count), .err_irq   (t_err_irq)
  );

  // The timeout instance talks to a slave that never answers.
  assign t_s_prdata  = {4{32'hDEAD_BEEF}};
  assign t_s_pready  = '0;
  assign t_s_pslverr = '0;

  always #5 FAB_CLK = ~FAB_CLK;

  always @(posedge FAB_CLK) cyc <= cyc + 1;

  // Count completed ACCESS cycles per slot.
  always @(posedge FAB_CLK) begin
    // NOTE: the slave counter updates with <= so the bridge samples the
    // ready level from before this edge, not the one it produces.
    for (int k = 0; k < 4; k++) begin
      acc_cnt[k] <= (s_psel[k] && s_penable) ? acc_cnt[k] + 1 : 0;
    end
  end

  // Slave responses: ready once the programmed number of waits has elapsed.
  always_comb begin
    s_prdata  = '0;
    s_pready  = '0;
    s_pslverr = '0;
    for (int k = 0; k < 4; k++) begin
      s_prdata[32*k +: 32] = sl_data[k];
      s_pready[k]  = s_psel[k] && s_penable && (sl_wait[k] >= 0) && (acc_cnt[k] == sl_wait[k]);
      s_pslverr[k] = sl_err[k];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_resp(input logic [31:0] data, input logic err, input int at_cyc);
    exp_t e;
    if (err && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    e.data = data;
    e.err  = err;
    e.cyc  = at_cyc;
    e.cnt  = model_cnt;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every m_pready must match the oldest expectation.
  always @(negedge FAB_CLK) begin
    if (m_pready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_pready: got m_pready=1 at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("m_prdata", m_prdata, mon_e.data);
        check("m_pslverr", 32'(m_pslverr), 32'(mon_e.err));
        check("pready_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("err_irq", 32'(err_irq), 32'(mon_e.err));
        check("err_count", 32'(err_count), 32'(mon_e.cnt));
        check("s_psel_in_resp", 32'(s_psel), 32'h0);
      end
    end
  end

  // One master transfer; returns at the negedge of the m_pready cycle so a
  // following call issues its setup in the very next cycle.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] exp_sel, input logic [31:0] exp_data,
                      input logic exp_err, input int lat);
    int  t0;
    bit  done;
    @(posedge FAB_CLK); #1;
    m_paddr   = addr;
    m_pwrite  = wr;
    m_pwdata  = wdata;
    m_psel    = 1'b1;
    m_penable = 1'b0;
    t0 = cyc;
    expect_resp(exp_data, exp_err, t0 + lat);
    @(posedge FAB_CLK); #1;
    m_penable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge FAB_CLK);
      if (m_pready) begin
        done = 1'b1;
      end else begin
        check("s_psel", 32'(s_psel), 32'(exp_sel));
        check("s_penable", 32'(s_penable), 32'((exp_sel != 4'b0) && (i > 0)));
        check("m_prdata_idle", m_prdata, 32'h0);
        if (exp_sel != 4'b0) begin
          check("s_paddr", 32'(s_paddr), 32'(addr[7:0]));
          check("s_pwrite", 32'(s_pwrite), 32'(wr));
          if (wr) check("s_pwdata", s_pwdata, wdata);
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL no_pready: got no m_pready for addr 0x%0h, expected one within 300 cycles", addr);
    end
  endtask

  task automatic idle();
    @(posedge FAB_CLK); #1;
    m_psel    = 1'b0;
    m_penable = 1'b0;
  endtask

  task automatic timeout_test();
    int t0, irq_cnt, seen_cyc;
    bit seen;
    @(posedge FAB_CLK); #1;
    t_m_paddr   = 32'h4005_0104;
    t_m_pwrite  = 1'b0;
    t_m_psel    = 1'b1;
    t_m_penable = 1'b0;
    t0 = cyc;
    @(posedge FAB_CLK); #1;
    t_m_penable = 1'b1;
    irq_cnt  = 0;
    seen     = 1'b0;
    seen_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge FAB_CLK);
      if (i == 0) check("to_s_psel", 32'(t_s_psel), 32'h2);
      if (t_err_irq) irq_cnt++;
      if (t_m_pready && !seen) begin
        seen     = 1'b1;
        seen_cyc = cyc;
        check("to_prdata", t_m_prdata, 32'h0);
        check("to_pslverr", 32'(t_m_pslverr), 32'h1);
        check("to_err_count", 32'(t_err_count), 32'h1);
      end
    end
    t_m_psel    = 1'b0;
    t_m_penable = 1'b0;
    check("to_pready_cycle", 32'(seen_cyc), 32'(t0 + 7));
    check("to_irq_pulses", 32'(irq_cnt), 32'h1);
    check("to_err_count_hold", 32'(t_err_count), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100 us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    FAB_RESET = 1'b1;
    repeat (2) @(posedge FAB_CLK);
    @(negedge FAB_CLK);
    check("rst_m_pready", 32'(m_pready), 32'h0);
    check("rst_m_prdata", m_prdata, 32'h0);
    check("rst_m_pslverr", 32'(m_pslverr), 32'h0);
    check("rst_s_psel", 32'(s_psel), 32'h0);
    check("rst_s_penable", 32'(s_penable), 32'h0);
    check("rst_s_paddr", 32'(s_paddr), 32'h0);
    check("rst_s_pwdata", s_pwdata, 32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    check("rst_err_irq", 32'(err_irq), 32'h0);
    @(posedge FAB_CLK); #1;
    FAB_RESET = 1'b0;

    // timeout on the short-timeout instance
    timeout_test();

    // slave programming
    sl_data[0] = 32'h0BAD_0000; sl_err[0] = 1'b1; sl_wait[0] = 1;
    sl_data[1] = 32'hCAFE_0001; sl_err[1] = 1'b0; sl_wait[1] = 0;
    sl_data[2] = 32'h2222_0002; sl_err[2] = 1'b0; sl_wait[2] = 2;
    sl_data[3] = 32'h3333_0003; sl_err[3] = 1'b0; sl_wait[3] = 5;

    // back-to-back: zero-wait read, waited write, unmapped, slave error, read
    xfer(32'h4005_0104, 1'b0, 32'h0,          4'b0010, 32'hCAFE_0001, 1'b0, 3);
    xfer(32'h4005_0310, 1'b1, 32'h1234_5678,  4'b1000, 32'h3333_0003, 1'b0, 8);
    xfer(32'h4006_0000, 1'b0, 32'h0,          4'b0000, 32'h0,         1'b1, 2);
    xfer(32'h4005_0500, 1'b1, 32'hFFFF_0000,  4'b0000, 32'h0,         1'b1, 2);
    xfer(32'h4005_0020, 1'b0, 32'h0,          4'b0001, 32'h0BAD_0000, 1'b1, 4);
    xfer(32'h4005_02FC, 1'b0, 32'h0,          4'b0100, 32'h2222_0002, 1'b0, 5);
    idle();

    // saturation: preload the counter just below the top, then two errors
    @(negedge FAB_CLK);
    force dut.err_cnt_q = 16'hFFFE;
    #2;
    release dut.err_cnt_q;
    model_cnt = 16'hFFFE;
    xfer(32'h4006_0000, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 2);
    xfer(32'h4006_0004, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 2);
    idle();

    // reset during a stalled ACCESS
    sl_wait[2] = -1;
    @(posedge FAB_CLK); #1;
    m_paddr = 32'h4005_0200; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    @(posedge FAB_CLK); #1;
    m_penable = 1'b1;
    repeat (3) @(posedge FAB_CLK);
    @(negedge FAB_CLK);
    check("stall_s_psel", 32'(s_psel), 32'h4);
    check("stall_s_penable", 32'(s_penable), 32'h1);
    @(posedge FAB_CLK); #1;
    FAB_RESET = 1'b1;
    @(posedge FAB_CLK); #1;
    FAB_RESET = 1'b0;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    model_cnt = '0;
    @(negedge FAB_CLK);
    check("abort_s_psel", 32'(s_psel), 32'h0);
    check("abort_s_penable", 32'(s_penable), 32'h0);
    check("abort_m_pready", 32'(m_pready), 32'h0);
    check("abort_err_count", 32'(err_count), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge FAB_CLK);
      check("abort_no_pready", 32'(m_pready), 32'h0);
    end

    // a normal transfer after the abort
    sl_wait[2] = 0;
    xfer(32'h4005_0208, 1'b0, 32'h0, 4'b0100, 32'h2222_0002, 1'b0, 3);
    idle();

    repeat (3) @(posedge FAB_CLK);
    @(negedge FAB_CLK);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
